// File: rtl/nn_result_classifier.sv
// nn_result_classifier: polls an NN accelerator status word over Avalon-MM, burst-reads the
// per-class result words and reports the signed argmax (class index and score).
//   clk, reset_n           : clock, synchronous active-low reset
//   start -> busy          : single-cycle request, busy while a classification runs
//   class_valid/id/score   : one-cycle result pulse, id/score held until the next result
//   error                  : one-cycle pulse on a non-OKAY response (or poll timeout)
//   m_*                    : Avalon-MM read master (single outstanding transaction)
// Optional: NN_CLASSIFIER_TIMEOUT_EN adds a poll timeout of TIMEOUT_CYCLES cycles.
module nn_result_classifier #(
   parameter int          NUM_CLASSES    = 10,
   parameter logic [12:0] STATUS_ADDR    = 13'h0000,
   parameter logic [12:0] RESULT_BASE    = 13'h0010,
   parameter int          POLL_GAP       = 4,
   parameter int          TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   output logic        busy,
   output logic        class_valid,
   output logic [3:0]  class_id,
   output logic [31:0] class_score,
   output logic        error,
   output logic        m_read,
   output logic [12:0] m_address,
   output logic [9:0]  m_burstcount,
   output logic        m_beginbursttransfer,
   input  logic [31:0] m_readdata,
   input  logic        m_readdatavalid,
   input  logic        m_waitrequest,
   input  logic [1:0]  m_response
);
   typedef enum logic [2:0] {IDLE, POLL_REQ, POLL_WAIT, GAP, BURST_REQ, BURST_DATA, REPORT} state_t;
   localparam logic [3:0] LAST_BEAT = 4'(NUM_CLASSES - 1);
   localparam logic [7:0] GAP_LAST  = 8'(POLL_GAP > 0 ? POLL_GAP - 1 : 0);
   state_t      r_state, w_next;
   logic [3:0]  r_beat, r_drain, r_idx;
   logic [31:0] r_max;
   logic [7:0]  r_gap;
   logic        r_bbt_sent;
   logic        w_rdv, w_resp_err, w_timeout, w_take, w_last, w_poll;
   // beats still owed by an abandoned burst are swallowed so they never look like status data
   assign w_rdv      = m_readdatavalid && (r_drain == 4'd0);
   assign w_resp_err = w_rdv && (m_response != 2'b00) && (r_state == POLL_WAIT || r_state == BURST_DATA);
   assign w_take     = (r_beat == 4'd0) || ($signed(m_readdata) > $signed(r_max));
   assign w_last     = (r_state == BURST_DATA) && w_rdv && !w_resp_err && (r_beat == LAST_BEAT);
   assign w_poll     = r_state inside {POLL_REQ, POLL_WAIT, GAP};
   assign busy       = (r_state != IDLE);
   assign error      = w_resp_err || w_timeout;
   assign m_beginbursttransfer = m_read && !r_bbt_sent;
`ifdef NN_CLASSIFIER_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] r_to_cnt;
   // counts from POLL_REQ entry; held at 0 in IDLE so each start begins afresh
   always_ff @(posedge clk) begin
      if (!reset_n || r_state == IDLE) r_to_cnt <= 16'd0;
      else if (w_poll) r_to_cnt <= r_to_cnt + 16'd1;
   end
   assign w_timeout = w_poll && (r_to_cnt == TO_LAST);
`else
   logic w_unused_to;
   assign w_unused_to = ^TIMEOUT_CYCLES ^ w_poll;
   assign w_timeout   = 1'b0;
`endif
   always_comb begin
      w_next       = r_state;
      m_read       = 1'b0;
      m_address    = 13'd0;
      m_burstcount = 10'd0;
      class_valid  = 1'b0;
      case (r_state)
         IDLE:       w_next = start ? POLL_REQ : IDLE;
         POLL_REQ: begin
            m_read       = (r_drain == 4'd0);
            m_address    = STATUS_ADDR;
            m_burstcount = 10'd1;
            w_next       = (m_read && !m_waitrequest) ? POLL_WAIT : POLL_REQ;
         end
         POLL_WAIT:  if (w_rdv) w_next = m_readdata[0] ? BURST_REQ : (POLL_GAP == 0 ? POLL_REQ : GAP);
         GAP:        w_next = (r_gap == GAP_LAST) ? POLL_REQ : GAP;
         BURST_REQ: begin
            m_read       = 1'b1;
            m_address    = RESULT_BASE;
            m_burstcount = 10'(NUM_CLASSES);
            w_next       = m_waitrequest ? BURST_REQ : BURST_DATA;
         end
         BURST_DATA: w_next = w_last ? REPORT : BURST_DATA;
         REPORT: begin
            class_valid = 1'b1;
            w_next      = IDLE;
         end
         default:    w_next = IDLE;
      endcase
      if (error) w_next = IDLE;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_beat      <= 4'd0;
         r_drain     <= 4'd0;
         r_gap       <= 8'd0;
         r_bbt_sent  <= 1'b0;
         r_max       <= 32'd0;
         r_idx       <= 4'd0;
         class_id    <= 4'd0;
         class_score <= 32'd0;
      end else begin
         r_state    <= w_next;
         r_bbt_sent <= m_read && m_waitrequest;
         r_gap      <= (r_state == GAP) ? r_gap + 8'd1 : 8'd0;
         r_beat     <= (r_state == BURST_DATA) ? r_beat + 4'(w_rdv) : 4'd0;
         if (r_state == BURST_DATA && w_rdv && w_take) begin
            r_max <= m_readdata;
            r_idx <= r_beat;
         end
         // the last beat is folded into the result directly so class_valid lands the next cycle
         if (w_last) begin
            class_id    <= w_take ? r_beat : r_idx;
            class_score <= w_take ? m_readdata : r_max;
         end
         if (w_resp_err && r_state == BURST_DATA) r_drain <= LAST_BEAT - r_beat;
         else if (w_timeout && r_drain == 4'd0)
            r_drain <= 4'(((r_state == POLL_WAIT) && !m_readdatavalid) || (m_read && !m_waitrequest));
         else if (m_readdatavalid && r_drain != 4'd0) r_drain <= r_drain - 4'd1;
      end
   end
endmodule

// File: tb/tb_nn_result_classifier.sv
// tb_nn_result_classifier: scoreboard bench for nn_result_classifier with a behavioural
// Avalon-MM slave (configurable waitrequest stalls, 1-cycle read latency, error injection).
module tb_nn_result_classifier;
   localparam int          NC = 10;
   localparam logic [12:0] ST = 13'h0000;
   localparam logic [12:0] RB = 13'h0010;
   localparam int          PG = 4;
   typedef struct { logic err; logic [3:0] id; logic [31:0] score; int lat; } exp_t;
   typedef struct { logic [31:0] d; logic [1:0] r; } beat_t;
   logic        clk, reset_n, start;
   logic        busy, class_valid, error, m_read, m_beginbursttransfer;
   logic [3:0]  class_id;
   logic [31:0] class_score, m_readdata;
   logic [12:0] m_address;
   logic [9:0]  m_burstcount;
   logic        m_readdatavalid, m_waitrequest;
   logic [1:0]  m_response;
   exp_t        sb[$];
   beat_t       beats[$];
   logic [31:0] scores [NC];
   int          n_tests, n_fail, cyc, start_cyc, done_cnt, last_lat;
   int          wait_cfg, not_done, err_beat, gap_period, poll_base, poll_cnt, last_poll_cyc, stall;
   logic [12:0] held_addr;
   logic        acc_prev;
   logic [3:0]  prev_id;
   logic [31:0] prev_score;
   nn_result_classifier #(.NUM_CLASSES(NC), .STATUS_ADDR(ST), .RESULT_BASE(RB), .POLL_GAP(PG),
                          .TIMEOUT_CYCLES(50)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .class_valid(class_valid),
      .class_id(class_id), .class_score(class_score), .error(error), .m_read(m_read),
      .m_address(m_address), .m_burstcount(m_burstcount), .m_beginbursttransfer(m_beginbursttransfer),
      .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .m_waitrequest(m_waitrequest),
      .m_response(m_response));
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   initial begin
      cyc = 0;
      forever @(posedge clk) cyc++;
   end
   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask
   // slave model and output monitor: drive at negedge, sample 1 time unit later
   initial begin
      beat_t b;
      exp_t  e;
      m_readdatavalid = 0; m_readdata = 0; m_response = 0; m_waitrequest = 0;
      poll_cnt = 0; last_poll_cyc = 0; stall = 0; held_addr = 0; acc_prev = 0;
      done_cnt = 0; last_lat = 0;
      forever begin
         @(negedge clk);
         if (beats.size() > 0) begin
            b = beats.pop_front();
            m_readdatavalid = 1; m_readdata = b.d; m_response = b.r;
         end else begin
            m_readdatavalid = 0; m_readdata = 0; m_response = 0;
         end
         if (acc_prev) check("read_drop", m_read, 0);
         acc_prev = 0;
         m_waitrequest = m_read && (stall < wait_cfg);
         if (m_read) begin
            check("bbt_first_only", m_beginbursttransfer, stall == 0);
            if (stall > 0) check("addr_hold", m_address, held_addr);
            if (stall == 0 && m_address == ST) begin
               if (poll_cnt > poll_base && gap_period > 0) check("poll_gap", cyc - last_poll_cyc, gap_period);
               last_poll_cyc = cyc;
            end
            if (m_waitrequest) begin
               held_addr = m_address;
               stall++;
            end else begin
               stall = 0;
               acc_prev = 1;
               if (m_address == ST) begin
                  check("bcnt_poll", m_burstcount, 1);
                  beats.push_back('{d: 32'((poll_cnt - poll_base >= not_done) ? 1 : 0), r: 2'b00});
                  poll_cnt++;
               end else begin
                  check("addr_burst", m_address, RB);
                  check("bcnt_burst", m_burstcount, NC);
                  for (int k = 0; k < NC; k++)
                     beats.push_back('{d: scores[k], r: (k == err_beat) ? 2'b10 : 2'b00});
               end
            end
         end
         #1;
         if (class_valid || error) begin
            last_lat = cyc - start_cyc;
            check("sb_pending", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("error_flag", error, e.err);
               check("valid_flag", class_valid, !e.err);
               check("class_id", class_id, e.id);
               check("class_score", class_score, e.score);
               if (e.lat >= 0) check("latency", last_lat, e.lat);
            end
            done_cnt++;
         end
      end
   end
   task automatic launch(input int w, input int nd, input int eb, input logic [3:0] id,
                         input logic [31:0] sc, input int lat, input logic err);
      wait_cfg = w; not_done = nd; err_beat = eb; poll_base = poll_cnt;
      sb.push_back('{err: err, id: id, score: sc, lat: lat});
      if (!err) begin
         prev_id = id;
         prev_score = sc;
      end
      @(negedge clk);
      start = 1;
      start_cyc = cyc;
      @(negedge clk);
      start = 0;
      check("busy_rise", busy, 1);
   endtask
   task automatic wait_done(input int budget);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
      #2;
      check("done_in_budget", done_cnt, d0 + 1);
      check("busy_fall", busy, 0);
   endtask
   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_valid"}, class_valid, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_id"}, class_id, 0);
      check({tag, "_score"}, class_score, 0);
      check({tag, "_read"}, m_read, 0);
      check({tag, "_addr"}, m_address, 0);
      check({tag, "_bcnt"}, m_burstcount, 0);
      check({tag, "_bbt"}, m_beginbursttransfer, 0);
   endtask
   initial begin
      logic [31:0] best;
      logic [3:0]  bidx;
      n_tests = 0; n_fail = 0; start_cyc = 0;
      reset_n = 0; start = 0;
      wait_cfg = 0; not_done = 0; err_beat = -1; gap_period = 0; poll_base = 0;
      prev_id = 0; prev_score = 0;
      for (int k = 0; k < NC; k++) scores[k] = 0;
      repeat (3) @(negedge clk);
      #1 check_idle_outputs("reset");
      reset_n = 1;
      @(negedge clk);
      // basic argmax, tie at 2/4 keeps the lower index, class_valid at cycle 14
      scores = '{32'd5, -32'sd3, 32'd100, 32'd7, 32'd100, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
      launch(0, 0, -1, 4'd2, 32'd100, 14, 0);
      wait_done(200);
      // reset asserted mid-burst for 3 cycles
      scores = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
      launch(0, 0, -1, 4'd9, 32'd10, -1, 0);
      repeat (6) @(negedge clk);
      reset_n = 0;
      repeat (3) @(negedge clk);
      #1 check_idle_outputs("midreset");
      sb.delete();
      prev_id = 0; prev_score = 0;
      reset_n = 1;
      repeat (20) @(negedge clk);
      // all negative, max -1 at index 9
      scores[0] = 32'h8000_0000;
      for (int k = 1; k < NC; k++) scores[k] = -(NC - k);
      launch(0, 0, -1, 4'd9, 32'hFFFF_FFFF, 14, 0);
      wait_done(200);
      // three not-done polls, two wait states per request
      scores = '{32'd10, 32'd20, 32'd30, -32'sd40, 32'd50, 32'd60, 32'd70, 32'd80, 32'd90, 32'd85};
      gap_period = 2 + 1 + 1 + PG;
      launch(2, 3, -1, 4'd8, 32'd90, -1, 0);
      wait_done(500);
      check("poll_count", poll_cnt - poll_base, 4);
      gap_period = 0;
      // error response on beat 4, second start while busy must be ignored
      scores = '{32'd1000, 32'd2000, 32'd3000, 32'd4000, 32'd5000, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
      launch(0, 0, 4, prev_id, prev_score, 8, 1);
      repeat (2) @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      wait_done(200);
      repeat (20) @(negedge clk);
      #1;
      check("err_idle", busy, 0);
      check("err_id_kept", class_id, 8);
      check("err_score_kept", class_score, 90);
      // random scores with assorted stalls and poll counts
      for (int t = 0; t < 3; t++) begin
         for (int k = 0; k < NC; k++) scores[k] = $urandom;
         if (t == 1) scores[6] = scores[3];
         best = scores[0]; bidx = 0;
         for (int k = 1; k < NC; k++)
            if ($signed(scores[k]) > $signed(best)) begin
               best = scores[k];
               bidx = 4'(k);
            end
         launch(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1, bidx, best, -1, 0);
         wait_done(500);
      end
`ifdef NN_CLASSIFIER_TIMEOUT_EN
      // status never reports done
      launch(0, 1000, -1, prev_id, prev_score, -1, 1);
      wait_done(200);
      check("timeout_window", last_lat <= 50, 1);
      repeat (10) @(negedge clk);
`endif
      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/nn_result_classifier.md
# nn_result_classifier

Downstream consumer of the neural-network accelerator's Avalon-MM slave. On a start pulse it polls the accelerator status word until calculation is done. It then burst-reads the per-class result words and computes a signed argmax. It reports the winning class index and score to the host-side logic.

## Interface

Parameters:
- NUM_CLASSES, 10: result words read per classification (1..16).
- STATUS_ADDR, 13'h0000: word address of the status register; bit 0 = calculation done.
- RESULT_BASE, 13'h0010: word address of class 0 result; class k at RESULT_BASE+k.
- POLL_GAP, 4: idle cycles between consecutive status polls (0..255).
- TIMEOUT_CYCLES, 65535: poll timeout; used only when the macro is compiled in.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request; ignored while busy.
- busy  out  1  high from cycle after accepted start until class_valid/error cycle inclusive.
- class_valid  out  1  one-cycle pulse; class_id/class_score valid.
- class_id  out  4  argmax index, held until next result.
- class_score  out  32  signed score of winning class, held.
- error  out  1  one-cycle pulse on nonzero response (or timeout).
- m_read  out  1  Avalon read request.
- m_address  out  13  Avalon word address.
- m_burstcount  out  10  Avalon burst length.
- m_beginbursttransfer  out  1  Avalon burst start strobe.
- m_readdata  in  32  Avalon read data.
- m_readdatavalid  in  1  Avalon read-data qualifier.
- m_waitrequest  in  1  Avalon stall.
- m_response  in  2  Avalon response, 2'b00 = OKAY.

## Operation

- Reset (reset_n low at clk edge): state IDLE; every output 0, including class_id, class_score, m_address, m_burstcount.
- FSM states: IDLE, POLL_REQ, POLL_WAIT, GAP, BURST_REQ, BURST_DATA, REPORT.
- IDLE --start--> POLL_REQ.
- POLL_REQ: m_read=1, m_address=STATUS_ADDR, m_burstcount=1, m_beginbursttransfer=1 on first request cycle only. Stay while m_waitrequest=1; on accept -> POLL_WAIT.
- POLL_WAIT: on m_readdatavalid:
  - m_readdata[0]=1 -> BURST_REQ.
  - Otherwise -> GAP, or POLL_REQ directly when POLL_GAP=0.
- GAP: counts POLL_GAP cycles, then -> POLL_REQ.
- BURST_REQ: m_read=1, m_address=RESULT_BASE, m_burstcount=NUM_CLASSES, m_beginbursttransfer=1 first cycle only. Hold until accepted -> BURST_DATA.
- BURST_DATA:
  - 4-bit beat counter increments per m_readdatavalid.
  - Beat 0 loads running max/index unconditionally.
  - Later beats replace only on strictly greater, signed 32-bit compare; ties keep the lower index.
  - After beat NUM_CLASSES-1 -> REPORT.
- REPORT: class_valid=1 one cycle, outputs updated, -> IDLE.
- Any readdatavalid beat with m_response≠0: error pulse, class_id/class_score unchanged, -> IDLE. Remaining beats of that burst are ignored until the next start.
- start while busy: ignored, no queuing. start in the REPORT cycle is also ignored.
- reset_n low mid-burst: immediate return to IDLE. In-flight readdatavalid beats arriving after reset are discarded.

## Timing

- Request signals stay stable while m_waitrequest=1; m_read drops the cycle after acceptance.
- Exactly one outstanding transaction at any time.
- busy rises the cycle after start is sampled.
- With zero wait states and 1-cycle read latency, status already done:
  - start sampled at cycle 0.
  - Poll request at cycle 1; status data at cycle 2.
  - Burst request at cycle 3; beats at cycles 4..3+NUM_CLASSES.
  - class_valid at cycle 4+NUM_CLASSES (cycle 14 for the default).
- Compare is registered: result available the cycle after the last beat.

## Configuration

- NN_CLASSIFIER_TIMEOUT_EN defined:
  - A 16-bit counter runs from POLL_REQ entry through POLL_WAIT/GAP.
  - It reaches TIMEOUT_CYCLES only if done is never seen.
  - On reaching it: error pulse, -> IDLE. The counter clears on each new start.
- Not defined: no counter logic; polling continues indefinitely.

## Test plan

- Reset: hold reset_n low 3 cycles during a burst -> all outputs 0, m_read 0, next start runs cleanly.
- Basic argmax: done on first poll, scores {5,-3,100,7,100,0,1,2,3,4} -> class_id=2, class_score=100, class_valid at cycle 14.
- Signed/negative: all scores negative, max -1 at index 9 -> class_id=9, class_score=32'hFFFF_FFFF.
- Polling + waitrequest: status reads 0 three times, waitrequest high 2 cycles per request -> exactly 4 polls with POLL_GAP idle between them, address stable while stalled, then a correct result.
- Error: m_response=2'b10 on beat 4 -> error pulse, class_valid stays 0, previous class_id/class_score retained, start ignored while busy.
- Timeout (macro on, TIMEOUT_CYCLES=50): status never done -> error pulse within 50 cycles of start, busy low after.
